// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte queue feeding uart_transceiver.
// Bytes from the bus side are stored in a circular buffer. A two-state
// launcher hands them to the transceiver one at a time, waiting for tx_done
// between bytes. Level, full/empty, sticky overflow and a drained pulse are
// reported back to software.
module uart_tx_fifo #(
    parameter int depth_log2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [depth_log2:0]   level,
    output logic                  overflow,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_done,
    output logic                  drained_irq
);

    localparam int DEPTH = 2 ** depth_log2;

    // Level value meaning "every entry occupied" (exactly 2**depth_log2).
    localparam logic [depth_log2:0]   LVL_FULL = {1'b1, {depth_log2{1'b0}}};
    localparam logic [depth_log2:0]   LVL_ONE  = {{depth_log2{1'b0}}, 1'b1};
    localparam logic [depth_log2-1:0] PTR_ONE  = {{(depth_log2-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]              r_mem [0:DEPTH-1];
    logic [depth_log2-1:0]   r_wr_ptr;
    logic [depth_log2-1:0]   r_rd_ptr;
    logic [depth_log2:0]     r_level;
    logic                    r_overflow;
    state_t                  r_state;
    logic [7:0]              r_tx_data;
    logic                    r_tx_wr;
    logic                    r_busy;
    logic                    r_drained;

    // ------------------------------------------------------------------
    // Combinational decodes
    // ------------------------------------------------------------------
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_launch;
    logic                    w_done_acc;
    state_t                  w_state_nxt;

    // Status flags come straight from the level counter.
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);

    // A push needs room now; a pop in the same cycle does not make room,
    // so a write at full is always rejected. Flush wins over a write.
    assign w_push = wr_en & ~w_full & ~flush;

    // The only consumer of queued bytes is the launcher.
    assign w_pop = w_launch;

    // ------------------------------------------------------------------
    // Launcher FSM
    // ------------------------------------------------------------------

    // State register; reset drops any byte in flight since the transceiver
    // is reset together with us.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: launch from IDLE when data is queued and not flushing,
    // leave WAIT on tx_done. tx_done in IDLE is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done_acc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !flush) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    w_done_acc  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------

    // Byte storage; contents are don't-care until written so no reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Read/write pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Level counter kept separately so full and empty are unambiguous.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow: any write attempt while full, unless flushed.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered transceiver interface and status
    // ------------------------------------------------------------------

    // Launch pulse and data latched from the head of the queue.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_tx_wr   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_tx_wr <= w_launch;
            if (w_launch) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Busy mirrors the WAIT state as a register of its own.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_WAIT);
        end
    end

    // Drained pulse: the finished byte was the last one and nothing new
    // arrived in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_drained <= 1'b0;
        end else begin
            r_drained <= w_done_acc & w_empty & ~w_push;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign full        = w_full;
    assign empty       = w_empty;
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign busy        = r_busy;
    assign tx_data     = r_tx_data;
    assign tx_wr       = r_tx_wr;
    assign drained_irq = r_drained;

endmodule
